// File: rtl/ov5640_power_seq.sv
// OV5640 power-up/reset sequencer: walks PWDN and RESETB through the datasheet timing,
// kicks off SCCB configuration, supervises it with a timeout and power-cycles on failure.
module ov5640_power_seq #(
    parameter logic [23:0] PWDN_CYCLES  = 24'd144_000,
    parameter logic [23:0] RESET_CYCLES = 24'd24_000,
    parameter logic [23:0] WAKE_CYCLES  = 24'd480_000,
    parameter logic [23:0] CFG_TIMEOUT  = 24'd2_400_000,
    parameter logic [1:0]  MAX_RETRY    = 2'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reinit,
    input  logic       init_done,
    output logic       cam_pwdn,
    output logic       cam_rst_n,
    output logic       init_start,
    output logic       power_done,
    output logic       cfg_err,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        S_PWDN  = 3'd0,
        S_RESET = 3'd1,
        S_WAKE  = 3'd2,
        S_START = 3'd3,
        S_CFG   = 3'd4,
        S_READY = 3'd5,
        S_FAIL  = 3'd6
    } state_t;

    state_t      state;
    state_t      nxt;
    logic [23:0] cnt;
    logic [1:0]  retry_cnt;
    logic        retry_inc;
    logic        retry_clr;
    logic        nxt_timed;

    always_comb begin
        nxt       = state;
        retry_inc = 1'b0;
        retry_clr = 1'b0;
        case (state)
            S_PWDN:  if (cnt == PWDN_CYCLES - 24'd1)  nxt = S_RESET;
            S_RESET: if (cnt == RESET_CYCLES - 24'd1) nxt = S_WAKE;
            S_WAKE:  if (cnt == WAKE_CYCLES - 24'd1)  nxt = S_START;
            S_START: nxt = S_CFG;
            S_CFG: begin
                // init_done wins over a coincident timeout
                if (init_done) begin
                    nxt = S_READY;
                end else if (cnt == CFG_TIMEOUT - 24'd1) begin
                    if (retry_cnt < MAX_RETRY) begin
                        nxt       = S_PWDN;
                        retry_inc = 1'b1;
                    end else begin
                        nxt = S_FAIL;
                    end
                end
            end
            S_READY, S_FAIL: begin
                if (reinit) begin
                    nxt       = S_PWDN;
                    retry_clr = 1'b1;
                end
            end
            default: nxt = S_PWDN;
        endcase
    end

    assign nxt_timed = (nxt == S_PWDN) || (nxt == S_RESET) || (nxt == S_WAKE) || (nxt == S_CFG);

    // Outputs are registered from the next state so pins change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_PWDN;
            cnt        <= 24'd0;
            retry_cnt  <= 2'd0;
            cam_pwdn   <= 1'b1;
            cam_rst_n  <= 1'b0;
            init_start <= 1'b0;
            power_done <= 1'b0;
            cfg_err    <= 1'b0;
            seq_state  <= 3'd0;
        end else begin
            state <= nxt;
            if (nxt != state || !nxt_timed) cnt <= 24'd0;
            else                           cnt <= cnt + 24'd1;
            if (retry_clr)                            retry_cnt <= 2'd0;
            else if (retry_inc && retry_cnt != 2'd3)  retry_cnt <= retry_cnt + 2'd1;
            cam_pwdn   <= (nxt == S_PWDN) || (nxt == S_FAIL);
            cam_rst_n  <= (nxt == S_WAKE) || (nxt == S_START) || (nxt == S_CFG) || (nxt == S_READY);
            init_start <= (nxt == S_START);
            power_done <= (nxt == S_READY);
            cfg_err    <= (nxt == S_FAIL);
            seq_state  <= nxt;
        end
    end

endmodule

// File: tb/tb_ov5640_power_seq.sv
// Bench for ov5640_power_seq: directed timeline scenarios plus random stimulus,
// all checked every cycle against a timeline model of the power-up sequence.
module tb_ov5640_power_seq;

    localparam int P  = 4;
    localparam int R  = 3;
    localparam int W  = 5;
    localparam int T  = 10;
    localparam int MR = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       reinit = 1'b0;
    logic       init_done = 1'b0;
    logic       cam_pwdn, cam_rst_n, init_start, power_done, cfg_err;
    logic [2:0] seq_state;

    int n_chk = 0;
    int n_err = 0;
    int edge_n = 0;
    bit armed = 1'b0;

    // model: mode 0 = sequencing, 1 = ready, 2 = failed; t = edges since attempt start
    int m_mode = 0;
    int m_t = 0;
    int m_retry = 0;

    ov5640_power_seq #(
        .PWDN_CYCLES(24'(P)), .RESET_CYCLES(24'(R)), .WAKE_CYCLES(24'(W)),
        .CFG_TIMEOUT(24'(T)), .MAX_RETRY(2'(MR))
    ) dut (
        .clk(clk), .rst(rst), .reinit(reinit), .init_done(init_done),
        .cam_pwdn(cam_pwdn), .cam_rst_n(cam_rst_n), .init_start(init_start),
        .power_done(power_done), .cfg_err(cfg_err), .seq_state(seq_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0d)", tag, got, exp, edge_n, $time);
        end
    endtask

    // Expected pins packed as {pwdn, rst_n, start, done, err, state[2:0]}
    function automatic logic [7:0] model_out();
        int c0 = P + R + W;
        if (m_mode == 1) return {5'b01010, 3'd5};
        if (m_mode == 2) return {5'b10001, 3'd6};
        if (m_t < P)         return {5'b10000, 3'd0};
        if (m_t < P + R)     return {5'b00000, 3'd1};
        if (m_t < c0)        return {5'b01000, 3'd2};
        if (m_t == c0)       return {5'b01100, 3'd3};
        return {5'b01000, 3'd4};
    endfunction

    always @(posedge clk) begin
        armed = 1'b1;
        if (rst) begin
            edge_n = 0;
            m_mode = 0; m_t = 0; m_retry = 0;
        end else begin
            edge_n++;
            if (m_mode == 0) begin
                if (m_t > P + R + W) begin
                    if (init_done) m_mode = 1;
                    else if (m_t - (P + R + W + 1) == T - 1) begin
                        if (m_retry < MR) begin m_t = 0; m_retry++; end
                        else m_mode = 2;
                    end else m_t++;
                end else m_t++;
            end else if (reinit) begin
                m_mode = 0; m_t = 0; m_retry = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed)
            check("pins", {24'd0, cam_pwdn, cam_rst_n, init_start, power_done, cfg_err, seq_state},
                  {24'd0, model_out()});
    end

    task automatic at_edge(input int k);
        int guard = 0;
        do begin
            @(posedge clk); #1;
            guard++;
        end while (edge_n < k && guard < 500);
        if (edge_n != k) check("edge_wait", edge_n, k);
    endtask

    task automatic do_reset();
        rst = 1'b1; reinit = 1'b0; init_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pins", {cam_pwdn, cam_rst_n, init_start, power_done, cfg_err, seq_state}, 8'b10000_000);
        rst = 1'b0;
    endtask

    initial begin
        // normal sequence with spurious init_done in PWDN and ignored reinit in WAKE
        do_reset();
        at_edge(2);  init_done = 1'b1;
        at_edge(3);  init_done = 1'b0; check("pwdn_e3", cam_pwdn, 1'b1);
        at_edge(4);  check("pwdn_e4", cam_pwdn, 1'b0);
        at_edge(6);  check("rstn_e6", cam_rst_n, 1'b0);
        at_edge(7);  check("rstn_e7", cam_rst_n, 1'b1);
        at_edge(8);  reinit = 1'b1;
        at_edge(9);  reinit = 1'b0;
        at_edge(11); check("start_e11", init_start, 1'b0);
        at_edge(12); check("start_e12", init_start, 1'b1);
        at_edge(13); check("start_e13", init_start, 1'b0);
        at_edge(16); init_done = 1'b1; check("done_e16", power_done, 1'b0);
        at_edge(17); check("done_e17", power_done, 1'b1); check("state_e17", seq_state, 3'd5);
        // reinit from READY restarts the full sequence
        at_edge(20); reinit = 1'b1; init_done = 1'b0;
        at_edge(21); reinit = 1'b0;
        check("reinit_done", power_done, 1'b0); check("reinit_pwdn", cam_pwdn, 1'b1);
        at_edge(33); check("restart_start", init_start, 1'b1);
        at_edge(40);

        // timeout, retry, then fail
        do_reset();
        at_edge(23); check("to_pwdn", cam_pwdn, 1'b1); check("to_rstn", cam_rst_n, 1'b0);
        at_edge(35); check("retry_start", init_start, 1'b1);
        at_edge(45); check("err_e45", cfg_err, 1'b0);
        at_edge(46); check("err_e46", cfg_err, 1'b1); check("state_e46", seq_state, 3'd6);
        at_edge(50); check("fail_hold", cfg_err, 1'b1);

        // init_done coincident with timeout wins
        do_reset();
        at_edge(22); init_done = 1'b1;
        at_edge(23); check("tie_state", seq_state, 3'd5); init_done = 1'b0;
        at_edge(26);

        // mid-sequence reset during WAKE
        do_reset();
        at_edge(9); rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_pins", {cam_pwdn, cam_rst_n, init_start, seq_state}, 6'b100_000);
        @(posedge clk); #1; rst = 1'b0;
        at_edge(4); check("mid_rst_pwdn", cam_pwdn, 1'b0);
        at_edge(12); check("mid_rst_start", init_start, 1'b1);

        // random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 299) == 0);
            init_done = ($urandom_range(0, 13) == 0);
            reinit    = ($urandom_range(0, 9) == 0);
        end
        rst = 1'b0; init_done = 1'b0; reinit = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
